// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32I core: forwarding selects,
// load-use / branch / IO-wait / debug-step stall and flush control.
module hazard_ctrl #(
    parameter int IO_LAT = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_wen,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       mem_rd,
    input  logic             mem_wen,
    input  logic [4:0]       wb_rd,
    input  logic             wb_wen,
    input  logic             ex_branch,
    input  logic             mem_io,
    input  logic             step_mode,
    input  logic             step_req,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_wb_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        IOWAIT = 2'd1,
        HALT   = 2'd2
    } state_t;

    localparam int CW = (IO_LAT > 1) ? $clog2(IO_LAT) : 1;

    state_t        cur_st;
    state_t        nxt_st;
    logic [CW-1:0] io_cnt;
    logic          io_go;
    logic          load_use;

    assign state = cur_st;
    assign io_go = mem_io && (IO_LAT != 0);

    // MEM result is younger than WB, so it wins when both match.
    always_comb begin
        fwd_a = 2'b00;
        if (mem_wen && mem_rd != 5'd0 && mem_rd == ex_rs1)
            fwd_a = 2'b01;
        else if (wb_wen && wb_rd != 5'd0 && wb_rd == ex_rs1)
            fwd_a = 2'b10;
    end

    always_comb begin
        fwd_b = 2'b00;
        if (mem_wen && mem_rd != 5'd0 && mem_rd == ex_rs2)
            fwd_b = 2'b01;
        else if (wb_wen && wb_rd != 5'd0 && wb_rd == ex_rs2)
            fwd_b = 2'b10;
    end

    assign load_use = ex_is_load && ex_wen && ex_rd != 5'd0 &&
                      ((id_use1 && id_rs1 == ex_rd) ||
                       (id_use2 && id_rs2 == ex_rd));

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_st <= RUN;
            io_cnt <= '0;
        end else begin
            cur_st <= nxt_st;
            if (cur_st == RUN && io_go)
                io_cnt <= CW'(IO_LAT - 1);
            else if (cur_st == IOWAIT && io_cnt != '0)
                io_cnt <= io_cnt - CW'(1);
        end
    end

    always_comb begin
        nxt_st = cur_st;
        unique case (cur_st)
            RUN: begin
                if (io_go)
                    nxt_st = IOWAIT;
                else if (step_mode)
                    nxt_st = HALT;
            end
            IOWAIT: begin
                if (io_cnt == '0)
                    nxt_st = RUN;
            end
            HALT: begin
                if (!step_mode || step_req)
                    nxt_st = RUN;
            end
            default: nxt_st = RUN;
        endcase
    end

    // Entry cycle of an IO wait masks branch/load-use; they re-evaluate later.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_flush = 1'b0;
        unique case (cur_st)
            RUN: begin
                if (io_go) begin
                    pc_stall = 1'b0;
                end else if (ex_branch) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                end
            end
            IOWAIT: begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_flush = 1'b1;
            end
            HALT: begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
            default: pc_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (pc_stall && !(&stall_cnt))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch,
// IO wait, debug step, reset and counter saturation.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
    logic       id_use1, id_use2, ex_wen, ex_is_load, mem_wen, wb_wen;
    logic       ex_branch, mem_io, step_mode, step_req;
    logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall;
    logic       id_ex_flush, ex_mem_stall, mem_wb_flush;
    logic [1:0] fwd_a, fwd_b, state;
    logic [3:0] stall_cnt;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int exp_cnt  = 0;

    hazard_ctrl #(.IO_LAT(2), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use1(id_use1), .id_use2(id_use2),
        .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .mem_rd(mem_rd), .mem_wen(mem_wen),
        .wb_rd(wb_rd), .wb_wen(wb_wen),
        .ex_branch(ex_branch), .mem_io(mem_io),
        .step_mode(step_mode), .step_req(step_req),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .if_id_flush(if_id_flush), .id_ex_stall(id_ex_stall),
        .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
        .mem_wb_flush(mem_wb_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .state(state), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clr();
        id_rs1 = 0; id_rs2 = 0; id_use1 = 0; id_use2 = 0;
        ex_rd = 0; ex_wen = 0; ex_is_load = 0; ex_rs1 = 0; ex_rs2 = 0;
        mem_rd = 0; mem_wen = 0; wb_rd = 0; wb_wen = 0;
        ex_branch = 0; mem_io = 0; step_mode = 0; step_req = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_cnt++;
        if (state !== 2'd0)
            $display("FAIL reset_state got %0d want 0", state);
        else pass_cnt++;
        chk_cnt++;
        if ({pc_stall, if_id_stall, if_id_flush, id_ex_stall,
             id_ex_flush, ex_mem_stall, mem_wb_flush} !== 7'b0)
            $display("FAIL reset_ctl got %b want 0", {pc_stall, if_id_stall,
                     if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall,
                     mem_wb_flush});
        else pass_cnt++;
        chk_cnt++;
        if ({fwd_a, fwd_b} !== 4'b0)
            $display("FAIL reset_fwd got %b want 0000", {fwd_a, fwd_b});
        else pass_cnt++;
        chk_cnt++;
        if (stall_cnt !== 4'd0)
            $display("FAIL reset_cnt got %0d want 0", stall_cnt);
        else pass_cnt++;
        exp_cnt = 0;
        tick();
    endtask

    task automatic test_fwd();
        clr();
        mem_wen = 1; mem_rd = 5'd1; ex_rs1 = 5'd1; ex_rs2 = 5'd1;
        #1;
        chk_cnt++;
        if ({fwd_a, fwd_b} !== 4'b0101)
            $display("FAIL fwd_mem got %b want 0101", {fwd_a, fwd_b});
        else pass_cnt++;
        mem_wen = 0; wb_wen = 1; wb_rd = 5'd1;
        #1;
        chk_cnt++;
        if ({fwd_a, fwd_b} !== 4'b1010)
            $display("FAIL fwd_wb got %b want 1010", {fwd_a, fwd_b});
        else pass_cnt++;
        mem_wen = 1; ex_rs2 = 5'd3;
        #1;
        chk_cnt++;
        if ({fwd_a, fwd_b} !== 4'b0100)
            $display("FAIL fwd_prio got %b want 0100", {fwd_a, fwd_b});
        else pass_cnt++;
        mem_rd = 5'd7; wb_rd = 5'd3;
        #1;
        chk_cnt++;
        if ({fwd_a, fwd_b} !== 4'b0010)
            $display("FAIL fwd_rs2_wb got %b want 0010", {fwd_a, fwd_b});
        else pass_cnt++;
        tick();
    endtask

    task automatic test_x0();
        clr();
        mem_wen = 1; mem_rd = 5'd0; wb_wen = 1; wb_rd = 5'd0;
        ex_rs1 = 5'd0; ex_rs2 = 5'd0;
        id_use1 = 1; id_rs1 = 5'd0;
        ex_is_load = 1; ex_wen = 1; ex_rd = 5'd0;
        #1;
        chk_cnt++;
        if ({fwd_a, fwd_b} !== 4'b0000)
            $display("FAIL x0_fwd got %b want 0000", {fwd_a, fwd_b});
        else pass_cnt++;
        chk_cnt++;
        if (pc_stall !== 1'b0 || id_ex_flush !== 1'b0)
            $display("FAIL x0_stall got %b%b want 00", pc_stall, id_ex_flush);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_load_use();
        clr();
        ex_is_load = 1; ex_wen = 1; ex_rd = 5'd5;
        id_use1 = 1; id_rs1 = 5'd5; id_use2 = 1; id_rs2 = 5'd0;
        #1;
        chk_cnt++;
        if ({pc_stall, if_id_stall, id_ex_flush, if_id_flush} !== 4'b1110)
            $display("FAIL lu_stall got %b want 1110",
                     {pc_stall, if_id_stall, id_ex_flush, if_id_flush});
        else pass_cnt++;
        tick();
        exp_cnt++;
        clr();
        mem_wen = 1; mem_rd = 5'd5; id_use1 = 1; id_rs1 = 5'd5;
        #1;
        chk_cnt++;
        if (pc_stall !== 1'b0 || id_ex_flush !== 1'b0)
            $display("FAIL lu_once got %b%b want 00", pc_stall, id_ex_flush);
        else pass_cnt++;
        chk_cnt++;
        if (stall_cnt !== 4'(exp_cnt))
            $display("FAIL lu_cnt got %0d want %0d", stall_cnt, exp_cnt);
        else pass_cnt++;
        tick();
        clr();
        wb_wen = 1; wb_rd = 5'd5; ex_rs1 = 5'd5; ex_rs2 = 5'd0;
        #1;
        chk_cnt++;
        if (fwd_a !== 2'b10)
            $display("FAIL lu_fwd got %b want 10", fwd_a);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_branch();
        clr();
        ex_is_load = 1; ex_wen = 1; ex_rd = 5'd9;
        id_use2 = 1; id_rs2 = 5'd9; ex_branch = 1;
        #1;
        chk_cnt++;
        if ({if_id_flush, id_ex_flush, pc_stall, if_id_stall} !== 4'b1100)
            $display("FAIL br_flush got %b want 1100",
                     {if_id_flush, id_ex_flush, pc_stall, if_id_stall});
        else pass_cnt++;
        tick();
        clr();
        #1;
        chk_cnt++;
        if (stall_cnt !== 4'(exp_cnt))
            $display("FAIL br_cnt got %0d want %0d", stall_cnt, exp_cnt);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_io();
        clr();
        mem_io = 1;
        #1;
        chk_cnt++;
        if (state !== 2'd0 || pc_stall !== 1'b0)
            $display("FAIL io_entry got st=%0d stl=%b want st=0 stl=0",
                     state, pc_stall);
        else pass_cnt++;
        tick();
        ex_branch = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk_cnt++;
            if (state !== 2'd1)
                $display("FAIL io_state%0d got %0d want 1", i, state);
            else pass_cnt++;
            chk_cnt++;
            if ({pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                 mem_wb_flush, if_id_flush} !== 6'b111110)
                $display("FAIL io_ctl%0d got %b want 111110", i,
                         {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                          mem_wb_flush, if_id_flush});
            else pass_cnt++;
            tick();
            exp_cnt++;
        end
        clr();
        #1;
        chk_cnt++;
        if (state !== 2'd0 || pc_stall !== 1'b0)
            $display("FAIL io_exit got st=%0d stl=%b want st=0 stl=0",
                     state, pc_stall);
        else pass_cnt++;
        chk_cnt++;
        if (stall_cnt !== 4'(exp_cnt))
            $display("FAIL io_cnt got %0d want %0d", stall_cnt, exp_cnt);
        else pass_cnt++;
        tick();
        mem_io = 1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_io = 0;
        #1;
        chk_cnt++;
        if (state !== 2'd0 || pc_stall !== 1'b0 || stall_cnt !== 4'd0)
            $display("FAIL io_rst got st=%0d stl=%b cnt=%0d want 0 0 0",
                     state, pc_stall, stall_cnt);
        else pass_cnt++;
        exp_cnt = 0;
        tick();
    endtask

    task automatic test_step();
        int fetches;
        clr();
        step_mode = 1;
        #1;
        chk_cnt++;
        if (pc_stall !== 1'b0)
            $display("FAIL step_enter got %b want 0", pc_stall);
        else pass_cnt++;
        tick();
        fetches = 0;
        for (int i = 0; i < 12; i++) begin
            step_req = (i == 2 || i == 5 || i == 8);
            #1;
            if (i == 0) begin
                chk_cnt++;
                if (state !== 2'd2 || id_ex_flush !== 1'b1)
                    $display("FAIL step_halt got st=%0d fl=%b want 2 1",
                             state, id_ex_flush);
                else pass_cnt++;
            end
            if (pc_stall == 1'b0)
                fetches++;
            tick();
        end
        step_req = 0;
        chk_cnt++;
        if (fetches !== 3)
            $display("FAIL step_fetch got %0d want 3", fetches);
        else pass_cnt++;
        step_mode = 0;
        tick();
        #1;
        chk_cnt++;
        if (state !== 2'd0 || pc_stall !== 1'b0)
            $display("FAIL step_exit got st=%0d stl=%b want 0 0",
                     state, pc_stall);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_saturate();
        clr();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        step_mode = 1;
        for (int i = 0; i < 22; i++)
            tick();
        #1;
        chk_cnt++;
        if (stall_cnt !== 4'hf)
            $display("FAIL sat_cnt got %0d want 15", stall_cnt);
        else pass_cnt++;
        clr();
        tick();
    endtask

    initial begin
        rst = 1'b0;
        clr();
        @(posedge clk);
        #1;
        test_reset();
        test_fwd();
        test_x0();
        test_load_use();
        test_branch();
        test_io();
        test_step();
        test_saturate();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
